// File: rtl/paddle_button_debounce.sv
// Two-button synchroniser + debounce FSMs feeding the paddle right/left inputs.
// Optional PRESS_CNT_EN adds saturating press counters per button.
module paddle_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 371250,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic       btn_right,
  input  logic       btn_left,
  output logic       right,
  output logic       left,
  output logic       right_press,
  output logic       left_press
`ifdef PRESS_CNT_EN
  ,
  output logic [7:0] right_cnt,
  output logic [7:0] left_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // bit 0 = right button, bit 1 = left button
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  state_t           state_q [2];
  state_t           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [1:0]       deb_q;
  logic [1:0]       deb_d;
  logic [1:0]       pulse_q;
  logic [1:0]       pulse_d;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_left, btn_right};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      deb_q   <= '0;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      deb_q   <= deb_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    deb_d   = deb_q;
    pulse_d = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (sync2[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!sync2[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
            deb_d[i]   = 1'b1;
            pulse_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync2[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (sync2[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            deb_d[i]   = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Both held cancels both directions; no priority between buttons.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      right       <= 1'b0;
      left        <= 1'b0;
      right_press <= 1'b0;
      left_press  <= 1'b0;
    end else begin
      right       <= deb_q[0] & ~deb_q[1];
      left        <= deb_q[1] & ~deb_q[0];
      right_press <= pulse_q[0];
      left_press  <= pulse_q[1];
    end
  end

`ifdef PRESS_CNT_EN
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      right_cnt <= '0;
      left_cnt  <= '0;
    end else begin
      if (pulse_q[0] && right_cnt != 8'hFF)
        right_cnt <= right_cnt + 8'd1;
      if (pulse_q[1] && left_cnt != 8'hFF)
        left_cnt <= left_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_paddle_button_debounce.sv
// Directed bench for paddle_button_debounce with DEBOUNCE_CYCLES=8.
// Define PRESS_CNT_EN to also exercise the press counters.
module tb_paddle_button_debounce;

  logic clk = 1'b0;
  logic rst;
  logic btn_right;
  logic btn_left;
  logic right;
  logic left;
  logic right_press;
  logic left_press;
`ifdef PRESS_CNT_EN
  logic [7:0] right_cnt;
  logic [7:0] left_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  paddle_button_debounce #(
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .pixel_clk  (clk),
    .rst        (rst),
    .btn_right  (btn_right),
    .btn_left   (btn_left),
    .right      (right),
    .left       (left),
    .right_press(right_press),
    .left_press (left_press)
`ifdef PRESS_CNT_EN
    ,
    .right_cnt  (right_cnt),
    .left_cnt   (left_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic br;
    logic bl;
    logic [3:0] exp;
  } vec_t;

  vec_t vt [12];

  function automatic logic [3:0] outs();
    return {right, left, right_press, left_press};
  endfunction

  task automatic check(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // {right, left, right_press, left_press} after each edge of a right press
    vt[0]  = '{1'b1, 1'b0, 4'b0000};
    vt[1]  = '{1'b1, 1'b0, 4'b0000};
    vt[2]  = '{1'b1, 1'b0, 4'b0000};
    vt[3]  = '{1'b1, 1'b0, 4'b0000};
    vt[4]  = '{1'b1, 1'b0, 4'b0000};
    vt[5]  = '{1'b1, 1'b0, 4'b0000};
    vt[6]  = '{1'b1, 1'b0, 4'b0000};
    vt[7]  = '{1'b1, 1'b0, 4'b0000};
    vt[8]  = '{1'b1, 1'b0, 4'b0000};
    vt[9]  = '{1'b1, 1'b0, 4'b0000};
    vt[10] = '{1'b1, 1'b0, 4'b1010};
    vt[11] = '{1'b1, 1'b0, 4'b1000};

    rst = 1'b1;
    btn_right = 1'b0;
    btn_left = 1'b0;
    tick(2);
    check("reset", {4'h0, outs()}, 8'h00);
    rst = 1'b0;
    tick(2);
    check("idle", {4'h0, outs()}, 8'h00);

    for (int i = 0; i < 12; i++) begin
      btn_right = vt[i].br;
      btn_left = vt[i].bl;
      tick(1);
      check($sformatf("rpress_%0d", i), {4'h0, outs()}, {4'h0, vt[i].exp});
    end

    btn_right = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      check($sformatf("rrel_%0d", k), {4'h0, outs()},
            (k < 11) ? 8'h08 : 8'h00);
    end

    for (int rep = 0; rep < 3; rep++) begin
      btn_left = 1'b1;
      for (int k = 0; k < 5; k++) begin
        tick(1);
        check("glitch_hi", {4'h0, outs()}, 8'h00);
      end
      btn_left = 1'b0;
      for (int k = 0; k < 2; k++) begin
        tick(1);
        check("glitch_lo", {4'h0, outs()}, 8'h00);
      end
    end
    for (int k = 0; k < 12; k++) begin
      tick(1);
      check("glitch_tail", {4'h0, outs()}, 8'h00);
    end

    btn_right = 1'b1;
    tick(11);
    check("both_r_on", {4'h0, outs()}, 8'h0A);
    tick(2);
    check("both_r_hold", {4'h0, outs()}, 8'h08);
    btn_left = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      check($sformatf("both_l_%0d", k), {4'h0, outs()},
            (k < 11) ? 8'h08 : 8'h01);
    end
    tick(3);
    check("both_held", {4'h0, outs()}, 8'h00);
    btn_left = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      check($sformatf("both_lrel_%0d", k), {4'h0, outs()},
            (k < 11) ? 8'h00 : 8'h08);
    end
    tick(1);
    check("both_after", {4'h0, outs()}, 8'h08);

    btn_right = 1'b0;
    tick(12);
    check("rst_pre", {4'h0, outs()}, 8'h00);
    btn_right = 1'b1;
    tick(7);
    rst = 1'b1;
    #1;
    check("rst_mid", {4'h0, outs()}, 8'h00);
    tick(2);
    check("rst_hold", {4'h0, outs()}, 8'h00);
    rst = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      check($sformatf("rst_req_%0d", k), {4'h0, outs()},
            (k < 11) ? 8'h00 : 8'h0A);
    end

    btn_right = 1'b0;
    tick(12);
    btn_left = 1'b1;
    tick(10);
    check("l_only_pre", {4'h0, outs()}, 8'h00);
    tick(1);
    check("l_only_on", {4'h0, outs()}, 8'h05);
    tick(1);
    check("l_only_hold", {4'h0, outs()}, 8'h04);
    btn_left = 1'b0;
    tick(12);
    check("l_only_rel", {4'h0, outs()}, 8'h00);

`ifdef PRESS_CNT_EN
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("cnt_rst_r", right_cnt, 8'h00);
    check("cnt_rst_l", left_cnt, 8'h00);
    for (int p = 1; p <= 300; p++) begin
      btn_right = 1'b1;
      tick(12);
      btn_right = 1'b0;
      tick(12);
      if (p == 1)
        check("cnt_one", right_cnt, 8'h01);
      if (p == 255)
        check("cnt_255", right_cnt, 8'hFF);
    end
    check("cnt_sat_r", right_cnt, 8'hFF);
    check("cnt_sat_l", left_cnt, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
